// File: rtl/ece571f23_g5_aes_pkg.sv
// Shared types, constants and lookup tables for the AES-128 key expansion block.
// The S-box table is packed MSB-first: entry 0 occupies bits [2047:2040].
package ece571f23_g5_aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef logic [127:0] round_key_t;
   typedef logic [31:0]  word_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } ks_state_e;

   localparam logic [2047:0] SBOX_TABLE = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Entry b sits at bit offset 8*(255-b) = {~b, 3'b000}.
   function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] r;
      case (rnd)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ece571f23_g5_aes_sbox.sv
// Single-byte AES forward S-box, purely combinational.
module ece571f23_g5_aes_sbox
   import ece571f23_g5_aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = sbox_lookup(in_byte);

endmodule

// File: rtl/ece571f23_g5_aes_keyexpand.sv
// AES-128 key expansion: one round key per cycle into an 11-entry flop array.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; stored keys readable when keys_valid
//   ST_EXPAND | computing key[rnd_q] from key[rnd_q-1], one per cycle
module ece571f23_g5_aes_keyexpand
   import ece571f23_g5_aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [3:0]   rd_round,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   output logic [127:0] rd_key
);

   ks_state_e  state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   logic       done_q, done_d;
   logic       valid_q, valid_d;
   round_key_t keys_q [NUM_ROUNDS+1];
   round_key_t keys_d [NUM_ROUNDS+1];

   round_key_t prev_key, next_key;
   word_t      rot_w, sub_w, t_w, w0, w1, w2, w3;

   always_comb begin
      prev_key = keys_q[0];
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
         if (rnd_q == 4'(i)) prev_key = keys_q[i-1];
      end
   end

   assign rot_w = {prev_key[23:0], prev_key[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      ece571f23_g5_aes_sbox u_sbox (
         .in_byte  (rot_w[8*g +: 8]),
         .out_byte (sub_w[8*g +: 8])
      );
   end

   assign t_w      = sub_w ^ {rcon(rnd_q), 24'h0};
   assign w0       = prev_key[127:96] ^ t_w;
   assign w1       = prev_key[95:64]  ^ w0;
   assign w2       = prev_key[63:32]  ^ w1;
   assign w3       = prev_key[31:0]   ^ w2;
   assign next_key = {w0, w1, w2, w3};

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      keys_d  = keys_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               keys_d[0] = key_in;
               rnd_d     = 4'd1;
               valid_d   = 1'b0;
               state_d   = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
               if (rnd_q == 4'(i)) keys_d[i] = next_key;
            end
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == 4'(NUM_ROUNDS)) begin
               done_d  = 1'b1;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rnd_q   <= 4'd0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++) keys_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         keys_q  <= keys_d;
      end
   end

   // Out-of-range indices and an incomplete schedule both read as zero.
   always_comb begin
      rd_key = '0;
      if (valid_q) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rd_round == 4'(i)) rd_key = keys_q[i];
         end
      end
   end

   assign busy       = (state_q == ST_EXPAND);
   assign done       = done_q;
   assign keys_valid = valid_q;

endmodule
